// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART serial transmitter with one-entry holding buffer
// Frames are start + 5..8 data bits LSB-first + stop; config latched at frame start.
module uart_tx_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bit_period,
  input  logic [3:0]  data_size,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        serial_out,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        full;
  logic [7:0]  hold_data;
  logic [7:0]  shreg;
  logic [13:0] cyc_cnt;
  logic [13:0] bp_l;
  logic [3:0]  bit_cnt;
  logic [3:0]  ds_l;

  logic [13:0] bp_clamp;
  logic [3:0]  ds_clamp;
  logic        bit_end;
  logic        frame_start;

  assign bp_clamp    = (bit_period == 14'd0) ? 14'd1 : bit_period;
  assign ds_clamp    = (data_size >= 4'd5 && data_size <= 4'd8) ? data_size : 4'd8;
  assign bit_end     = (cyc_cnt == bp_l);
  // The buffer is only consumed when it is full, so a load and an unload never coincide.
  assign frame_start = full && ((state == IDLE) || (state == STOP && bit_end));
  assign tx_ready    = ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      full       <= 1'b0;
      hold_data  <= 8'd0;
      shreg      <= 8'd0;
      cyc_cnt    <= 14'd0;
      bit_cnt    <= 4'd0;
      bp_l       <= 14'd1;
      ds_l       <= 4'd8;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_valid && !full) begin
        full      <= 1'b1;
        hold_data <= tx_data;
      end

      if (frame_start) begin
        full       <= 1'b0;
        shreg      <= hold_data;
        bp_l       <= bp_clamp;
        ds_l       <= ds_clamp;
        state      <= START;
        cyc_cnt    <= 14'd1;
        bit_cnt    <= 4'd0;
        serial_out <= 1'b0;
        tx_busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cyc_cnt    <= 14'd0;
            bit_cnt    <= 4'd0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
          end
          START: begin
            if (bit_end) begin
              state      <= DATA;
              cyc_cnt    <= 14'd1;
              bit_cnt    <= 4'd1;
              serial_out <= shreg[0];
            end else begin
              cyc_cnt <= cyc_cnt + 14'd1;
            end
          end
          DATA: begin
            if (bit_end) begin
              cyc_cnt <= 14'd1;
              if (bit_cnt == ds_l) begin
                state      <= STOP;
                bit_cnt    <= 4'd0;
                serial_out <= 1'b1;
                tx_done    <= (bp_l == 14'd1);
              end else begin
                shreg      <= {1'b0, shreg[7:1]};
                serial_out <= shreg[1];
                bit_cnt    <= bit_cnt + 4'd1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + 14'd1;
            end
          end
          STOP: begin
            if (bit_end) begin
              state      <= IDLE;
              cyc_cnt    <= 14'd0;
              serial_out <= 1'b1;
              tx_busy    <= 1'b0;
            end else begin
              cyc_cnt <= cyc_cnt + 14'd1;
              // Registered pulse: raise it for the cycle in which the count reaches bp_l.
              tx_done <= ((cyc_cnt + 14'd1) == bp_l);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        serial_out;
  logic        tx_busy;
  logic        tx_done;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int done_seen = 0;
  int snap;

  uart_tx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bit_period (bit_period),
    .data_size  (data_size),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks frame cycles c_from..c_to (1-based) and advances one negedge per cycle.
  task automatic run_frame(input logic [7:0] d, input int ds, input int bp,
                           input int c_from, input int c_to);
    for (int c = c_from; c <= c_to; c++) begin
      int   idx;
      logic es;
      idx = (c - 1) / bp;
      if (idx == 0)       es = 1'b0;
      else if (idx <= ds) es = d[idx-1];
      else                es = 1'b1;
      chk($sformatf("serial_%0h_c%0d", d, c), {31'd0, serial_out}, {31'd0, es});
      chk($sformatf("done_%0h_c%0d", d, c), {31'd0, tx_done}, (c == (ds + 2) * bp) ? 32'd1 : 32'd0);
      chk($sformatf("busy_%0h_c%0d", d, c), {31'd0, tx_busy}, 32'd1);
      @(negedge clk);
    end
  endtask

  // From idle: handshake one byte and stop at the first start-bit cycle.
  task automatic start_frame(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    chk("hs_ready_low", {31'd0, tx_ready}, 32'd0);
    chk("hs_busy_low", {31'd0, tx_busy}, 32'd0);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("start_ready_high", {31'd0, tx_ready}, 32'd1);
    chk("start_busy_high", {31'd0, tx_busy}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bit_period = 14'd4;
    data_size  = 4'd8;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_serial", {31'd0, serial_out}, 32'd1);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 frame, 0xA5, 4 cycles per bit
    start_frame(8'hA5);
    run_frame(8'hA5, 8, 4, 1, 40);
    chk("a5_idle_serial", {31'd0, serial_out}, 32'd1);
    chk("a5_idle_busy", {31'd0, tx_busy}, 32'd0);

    // 5-bit frame, then out-of-range size (8 bits); load on the STOP exit edge goes via IDLE
    bit_period = 14'd2;
    data_size  = 4'd5;
    start_frame(8'hFF);
    run_frame(8'hFF, 5, 2, 1, 14);
    data_size = 4'd0;
    start_frame(8'h3C);
    run_frame(8'h3C, 8, 2, 1, 19);
    tx_valid   = 1'b1;
    tx_data    = 8'hC3;
    bit_period = 14'd0;
    data_size  = 4'd7;
    run_frame(8'h3C, 8, 2, 20, 20);
    chk("stopload_serial", {31'd0, serial_out}, 32'd1);
    chk("stopload_busy", {31'd0, tx_busy}, 32'd0);
    chk("stopload_ready", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("stopload_start_busy", {31'd0, tx_busy}, 32'd1);
    chk("stopload_start_ready", {31'd0, tx_ready}, 32'd1);
    run_frame(8'hC3, 7, 1, 1, 9);

    // Back-to-back with tx_valid held: 0x00 then 0xFF
    bit_period = 14'd3;
    data_size  = 4'd8;
    snap = done_seen;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    chk("b2b_ready_low", {31'd0, tx_ready}, 32'd0);
    tx_data = 8'hFF;
    @(negedge clk);
    chk("b2b_ready_high", {31'd0, tx_ready}, 32'd1);
    run_frame(8'h00, 8, 3, 1, 1);
    tx_valid = 1'b0;
    chk("b2b_second_loaded", {31'd0, tx_ready}, 32'd0);
    run_frame(8'h00, 8, 3, 2, 30);
    run_frame(8'hFF, 8, 3, 1, 30);
    chk("b2b_idle_busy", {31'd0, tx_busy}, 32'd0);
    chk("b2b_done_count", done_seen - snap, 32'd2);

    // Backpressure: third byte waits while the buffer holds the second
    bit_period = 14'd2;
    data_size  = 4'd5;
    tx_valid = 1'b1;
    tx_data  = 8'h15;
    @(negedge clk);
    tx_data = 8'h0A;
    @(negedge clk);
    run_frame(8'h15, 5, 2, 1, 1);
    chk("bp_b_loaded", {31'd0, tx_ready}, 32'd0);
    tx_data = 8'h1B;
    run_frame(8'h15, 5, 2, 2, 14);
    chk("bp_ready_after_stop", {31'd0, tx_ready}, 32'd1);
    run_frame(8'h0A, 5, 2, 1, 1);
    chk("bp_c_loaded", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    run_frame(8'h0A, 5, 2, 2, 14);
    run_frame(8'h1B, 5, 2, 1, 14);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_idle_busy_%0d", i), {31'd0, tx_busy}, 32'd0);
      @(negedge clk);
    end

    // Mid-frame bit_period change applies to the next frame only
    bit_period = 14'd4;
    data_size  = 4'd8;
    start_frame(8'h0F);
    run_frame(8'h0F, 8, 4, 1, 10);
    bit_period = 14'd8;
    run_frame(8'h0F, 8, 4, 11, 40);
    start_frame(8'h81);
    run_frame(8'h81, 8, 8, 1, 80);

    // Reset during DATA with a byte waiting in the buffer
    bit_period = 14'd4;
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    @(negedge clk);
    tx_data = 8'h55;
    @(negedge clk);
    run_frame(8'hAA, 8, 4, 1, 1);
    tx_valid = 1'b0;
    run_frame(8'hAA, 8, 4, 2, 12);
    snap = done_seen;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_serial", {31'd0, serial_out}, 32'd1);
    chk("mrst_ready", {31'd0, tx_ready}, 32'd1);
    chk("mrst_busy", {31'd0, tx_busy}, 32'd0);
    chk("mrst_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk($sformatf("mrst_idle_busy_%0d", i), {31'd0, tx_busy}, 32'd0);
      chk($sformatf("mrst_idle_serial_%0d", i), {31'd0, serial_out}, 32'd1);
    end
    chk("mrst_no_done", done_seen - snap, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
